grid_puzzle_engine: RTL



---
 rtl/grid_puzzle_engine.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/grid_puzzle_engine.sv
// N x N puzzle grid engine: LFSR scramble, user row/column moves, move counter
// and registered win detection.
module grid_puzzle_engine #(
  parameter int          N              = 4,
  parameter int          W              = 2,
  parameter int          SCRAMBLE_MOVES = 16,
  parameter int          CNT_W          = 14,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fire,
  input  logic               nRow,
  input  logic [N-1:0]       sel,
  input  logic               add_n,
  input  logic               start,
  output logic [N*N*W-1:0]   grid_state,
  output logic [CNT_W-1:0]   moves,
  output logic               busy,
  output logic               win,
  output logic               error
);

  localparam int              IDX_W    = $clog2(N);
  localparam int              GW       = N * N * W;
  localparam logic [IDX_W:0]  N_EXT    = (IDX_W + 1)'(N);
  localparam logic [7:0]      SCR_LOAD = 8'(SCRAMBLE_MOVES);
  localparam logic [W-1:0]    ONE_W    = 1;
  localparam logic [CNT_W-1:0] ONE_C   = 1;
  localparam logic [N-1:0]    ONE_N    = 1;

  typedef enum logic [1:0] {S_SCRAMBLE, S_PLAY, S_WON} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    grid_q, grid_d;
  logic [CNT_W-1:0] moves_q, moves_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [7:0]       scnt_q, scnt_d;
  logic             check_q, check_d;

  logic             mv_en, mv_col, mv_dec;
  logic [N-1:0]     mv_line;
  logic [IDX_W:0]   raw_idx, fix_idx;
  logic [N-1:0]     scr_oh;
  logic             all_eq;
  logic             hit;

  assign error = ($countones(sel) != 1);

  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    moves_d = moves_q;
    scnt_d  = scnt_q;
    check_d = 1'b0;
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    mv_en   = 1'b0;
    mv_col  = 1'b0;
    mv_dec  = 1'b0;
    mv_line = '0;
    hit     = 1'b0;

    // Scramble line index folds out-of-range values back once for non power-of-2 N.
    raw_idx = {1'b0, lfsr_q[IDX_W-1:0]};
    fix_idx = (raw_idx >= N_EXT) ? (raw_idx - N_EXT) : raw_idx;
    scr_oh  = ONE_N << fix_idx[IDX_W-1:0];

    all_eq = 1'b1;
    for (int i = 1; i < N * N; i++) begin
      if (grid_q[i*W +: W] != grid_q[W-1:0]) all_eq = 1'b0;
    end

    case (state_q)
      S_SCRAMBLE: begin
        if (scnt_q != 8'd0) begin
          mv_en   = 1'b1;
          mv_col  = lfsr_q[15];
          mv_line = scr_oh;
          scnt_d  = scnt_q - 8'd1;
        end else begin
          state_d = S_PLAY;
          moves_d = '0;
        end
      end
      S_PLAY: begin
        if (start) begin
          state_d = S_SCRAMBLE;
          scnt_d  = SCR_LOAD;
          moves_d = '0;
        end else if (check_q && all_eq) begin
          state_d = S_WON;
        end else if (fire && !error) begin
          mv_en   = 1'b1;
          mv_col  = nRow;
          mv_line = sel;
          mv_dec  = add_n;
          moves_d = (&moves_q) ? moves_q : moves_q + ONE_C;
          check_d = 1'b1;
        end
      end
      S_WON: begin
        if (start) begin
          state_d = S_SCRAMBLE;
          scnt_d  = SCR_LOAD;
          moves_d = '0;
        end
      end
      default: state_d = S_SCRAMBLE;
    endcase

    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        hit = mv_col ? mv_line[c] : mv_line[r];
        if (mv_en && hit) begin
          grid_d[(r*N+c)*W +: W] = mv_dec ? grid_q[(r*N+c)*W +: W] - ONE_W
                                          : grid_q[(r*N+c)*W +: W] + ONE_W;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SCRAMBLE;
      grid_q  <= '0;
      moves_q <= '0;
      lfsr_q  <= SEED;
      scnt_q  <= SCR_LOAD;
      check_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      moves_q <= moves_d;
      lfsr_q  <= lfsr_d;
      scnt_q  <= scnt_d;
      check_q <= check_d;
    end
  end

  assign grid_state = grid_q;
  assign moves      = moves_q;
  assign busy       = (state_q == S_SCRAMBLE);
  assign win        = (state_q == S_WON);

endmodule
